eth_tx_frame_arb: RTL



---
 rtl/eth_tx_arb_pkg.sv | 27 ++
 rtl/eth_tx_arb_rr.sv | 44 ++++
 rtl/eth_tx_frame_arb.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_arb_pkg.sv
// ----------------------------------------------------------------------------
// eth_tx_arb_pkg
//   Shared definitions for the tx-side frame arbiter (eth_tx_frame_arb):
//   FSM state encodings, the grant index width helper and the width of the
//   stall counter used when ETH_TX_ARB_STALL_ABORT_EN is defined.
// ----------------------------------------------------------------------------
package eth_tx_arb_pkg;

    // Arbiter FSM encoding. ABORT and DROP only exist when the stall-abort
    // feature is compiled in, but the encoding is kept fixed so that grant
    // status decoders elsewhere see the same values in both builds.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] ABORT  = 2'd2;
    localparam logic [1:0] DROP   = 2'd3;

    // Width of the counter that measures how long a granted source has
    // held tvalid low in the middle of a frame.
    localparam int STALL_CNT_W = 16;

    // Number of bits needed to hold a port index; never less than one so a
    // degenerate configuration still elaborates.
    function automatic int grant_idx_width(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

endpackage

// File: rtl/eth_tx_arb_rr.sv
// ----------------------------------------------------------------------------
// eth_tx_arb_rr
//   Combinational rotating priority encoder. Starting one position past
//   last_index and wrapping modulo PORTS, it reports the first port whose
//   request bit is set.
//
//   Ports:
//     req         in   PORTS   request vector (one bit per port)
//     last_index  in   IDX_W   most recently granted port (round-robin pointer)
//     found       out  1       at least one request is present
//     next_index  out  IDX_W   selected port; equals last_index when !found
// ----------------------------------------------------------------------------
module eth_tx_arb_rr
    import eth_tx_arb_pkg::*;
#(
    parameter int PORTS = 4
) (
    input  logic [PORTS-1:0]                  req,
    input  logic [grant_idx_width(PORTS)-1:0] last_index,
    output logic                              found,
    output logic [grant_idx_width(PORTS)-1:0] next_index
);

    localparam int IDX_W = grant_idx_width(PORTS);

    logic [IDX_W-1:0] cand;

    // Walk the ports in priority order (last_index+1 first, last_index
    // itself last) and latch the first requester seen. The modulo keeps
    // the candidate inside 0..PORTS-1 for non power-of-two port counts.
    always_comb begin
        found      = 1'b0;
        next_index = last_index;
        cand       = '0;
        for (int off = 1; off <= PORTS; off++) begin
            cand = IDX_W'((int'(last_index) + off) % PORTS);
            if (!found && req[cand]) begin
                found      = 1'b1;
                next_index = cand;
            end
        end
    end

endmodule

// File: rtl/eth_tx_frame_arb.sv
// ----------------------------------------------------------------------------
// eth_tx_frame_arb
//   Frame-granular round-robin arbiter sharing one MAC tx AXI-stream input
//   among PORTS requesters in the tx_clk domain. A grant is taken on the
//   first beat of a frame and held until that frame's tlast is accepted, so
//   frames never interleave. One IDLE cycle separates consecutive frames.
//
//   Optional feature (define ETH_TX_ARB_STALL_ABORT_EN):
//     If the granted source holds tvalid low mid-frame for STALL_TIMEOUT
//     cycles, the arbiter closes the frame on the MAC side with a tlast+tuser
//     beat of zero data, pulses frame_abort, then silently drains the rest of
//     the source's frame. Without the macro a stall waits indefinitely and
//     frame_abort is tied low.
//
//   Ports:
//     clk            in   1                  tx clock, rising edge
//     rst            in   1                  synchronous active-high reset
//     s_axis_tdata   in   PORTS*DATA_WIDTH   port i at [i*DATA_WIDTH +: DATA_WIDTH]
//     s_axis_tvalid  in   PORTS              per-port valid
//     s_axis_tready  out  PORTS              per-port ready
//     s_axis_tlast   in   PORTS              per-port end of frame
//     s_axis_tuser   in   PORTS              per-port bad-frame flag
//     m_axis_tdata   out  DATA_WIDTH         to MAC
//     m_axis_tvalid  out  1                  to MAC
//     m_axis_tready  in   1                  from MAC
//     m_axis_tlast   out  1                  to MAC
//     m_axis_tuser   out  1                  to MAC
//     grant_valid    out  1                  a frame is currently granted
//     grant_index    out  $clog2(PORTS)      current or last granted port
//     frame_abort    out  1                  one-cycle pulse on a stall abort
// ----------------------------------------------------------------------------
module eth_tx_frame_arb
    import eth_tx_arb_pkg::*;
#(
    parameter int PORTS         = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int STALL_TIMEOUT = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PORTS*DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [PORTS-1:0]                  s_axis_tvalid,
    output logic [PORTS-1:0]                  s_axis_tready,
    input  logic [PORTS-1:0]                  s_axis_tlast,
    input  logic [PORTS-1:0]                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tuser,
    output logic                              grant_valid,
    output logic [grant_idx_width(PORTS)-1:0] grant_index,
    output logic                              frame_abort
);

    localparam int IDX_W = grant_idx_width(PORTS);

    // Reject configurations the arbiter is not built for.
    if (PORTS < 2 || PORTS > 8 || STALL_TIMEOUT < 1) begin : g_cfg_check
        $error("eth_tx_frame_arb: PORTS must be 2..8 and STALL_TIMEOUT >= 1");
    end

    logic [1:0]            state;
    logic                  rr_found;
    logic [IDX_W-1:0]      rr_next;

    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  sel_user;

    // Signals of the port currently pointed at by grant_index. Outside
    // ACTIVE these are simply ignored by the output logic.
    assign sel_data  = s_axis_tdata[grant_index*DATA_WIDTH +: DATA_WIDTH];
    assign sel_valid = s_axis_tvalid[grant_index];
    assign sel_last  = s_axis_tlast[grant_index];
    assign sel_user  = s_axis_tuser[grant_index];

    eth_tx_arb_rr #(
        .PORTS (PORTS)
    ) u_rr (
        .req        (s_axis_tvalid),
        .last_index (grant_index),
        .found      (rr_found),
        .next_index (rr_next)
    );

    // Output steering. In ACTIVE the granted port is a transparent wire to
    // the MAC and sees the MAC's ready; every other port is held off. IDLE
    // presents nothing, which is what gives the one-cycle arbitration gap.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        case (state)
            ACTIVE: begin
                m_axis_tdata               = sel_data;
                m_axis_tvalid              = sel_valid;
                m_axis_tlast               = sel_last;
                m_axis_tuser               = sel_user;
                s_axis_tready[grant_index] = m_axis_tready;
            end
`ifdef ETH_TX_ARB_STALL_ABORT_EN
            // Close the truncated frame towards the MAC as a marked-bad frame.
            ABORT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = 1'b1;
            end
            // Swallow whatever is left of the aborted frame at the source.
            DROP: begin
                s_axis_tready[grant_index] = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

`ifdef ETH_TX_ARB_STALL_ABORT_EN
    logic [STALL_CNT_W-1:0] stall_cnt;
`else
    assign frame_abort = 1'b0;
`endif

    // Frame-level FSM. grant_index is only rewritten on a new grant, so it
    // doubles as the round-robin pointer while idle. With the stall-abort
    // build, the stall counter compares before it increments: a source that
    // shows tvalid in the cycle the count hits the limit keeps its frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_index <= IDX_W'(PORTS - 1);
`ifdef ETH_TX_ARB_STALL_ABORT_EN
            stall_cnt   <= '0;
            frame_abort <= 1'b0;
`endif
        end else begin
`ifdef ETH_TX_ARB_STALL_ABORT_EN
            frame_abort <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (rr_found) begin
                        grant_index <= rr_next;
                        grant_valid <= 1'b1;
                        state       <= ACTIVE;
`ifdef ETH_TX_ARB_STALL_ABORT_EN
                        stall_cnt   <= '0;
`endif
                    end
                end
                ACTIVE: begin
                    if (sel_valid && m_axis_tready && sel_last) begin
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                    end
`ifdef ETH_TX_ARB_STALL_ABORT_EN
                    if (sel_valid) begin
                        stall_cnt <= '0;
                    end else if (stall_cnt == STALL_CNT_W'(STALL_TIMEOUT)) begin
                        state       <= ABORT;
                        frame_abort <= 1'b1;
                        stall_cnt   <= '0;
                    end else begin
                        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
                    end
`endif
                end
`ifdef ETH_TX_ARB_STALL_ABORT_EN
                ABORT: begin
                    if (m_axis_tready) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (sel_valid && sel_last) begin
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                    end
                end
`endif
                default: begin
                    state       <= IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
